// File: rtl/fft_reorder_pp.sv
// Ping-pong bit-reversal reorder buffer: frames arrive in bit-reversed order and leave in natural order, LANES samples per beat.
// Optional FFT_REORDER_FRAME_CNT_EN adds the frame_cnt and drop_err status outputs.
module fft_reorder_pp #(
    parameter int N     = 512,
    parameter int LANES = 16,
    parameter int W     = 13
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      din_valid,
    output logic                      din_ready,
    input  logic [LANES-1:0][W-1:0]   din_i,
    input  logic [LANES-1:0][W-1:0]   din_q,
    output logic                      dout_valid,
    input  logic                      dout_ready,
    output logic [LANES-1:0][W-1:0]   dout_i,
    output logic [LANES-1:0][W-1:0]   dout_q,
    output logic                      dout_sof,
    output logic                      dout_eof
`ifdef FFT_REORDER_FRAME_CNT_EN
    ,
    output logic [15:0]               frame_cnt,
    output logic                      drop_err
`endif
);

    localparam int B  = N / LANES;
    localparam int L  = $clog2(N);
    localparam int CW = (B > 1) ? $clog2(B) : 1;
    localparam logic [CW-1:0] LAST = CW'(B - 1);

    typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_state_e;

    bank_state_e   bank_q [2];
    bank_state_e   bank_d [2];
    logic          wr_sel_q, wr_sel_d;
    logic          rd_sel_q, rd_sel_d;
    logic [CW-1:0] wr_cnt_q, wr_cnt_d;
    logic [CW-1:0] rd_cnt_q, rd_cnt_d;

    logic [W-1:0]  mem_i [2][N];
    logic [W-1:0]  mem_q [2][N];
    logic [L-1:0]  raddr [LANES];

    logic wr_fire, rd_fire;

    function automatic logic [L-1:0] bitrev(input logic [L-1:0] a);
        logic [L-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < L; i++) begin
            r[i] = a[L-1-i];
        end
        return r;
    endfunction

    always_comb begin
        din_ready  = (bank_q[wr_sel_q] == EMPTY) || (bank_q[wr_sel_q] == FILLING);
        dout_valid = (bank_q[rd_sel_q] == FULL)  || (bank_q[rd_sel_q] == DRAINING);
        wr_fire    = din_valid && din_ready;
        rd_fire    = dout_valid && dout_ready;
        dout_sof   = (rd_cnt_q == '0);
        dout_eof   = (rd_cnt_q == LAST);
    end

    // Write and read only ever target different banks (disjoint states), so both may act on one edge.
    always_comb begin
        bank_d[0] = bank_q[0];
        bank_d[1] = bank_q[1];
        wr_sel_d  = wr_sel_q;
        rd_sel_d  = rd_sel_q;
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        if (wr_fire) begin
            if (wr_cnt_q == LAST) begin
                bank_d[wr_sel_q] = FULL;
                wr_cnt_d         = '0;
                wr_sel_d         = ~wr_sel_q;
            end else begin
                bank_d[wr_sel_q] = FILLING;
                wr_cnt_d         = wr_cnt_q + CW'(1);
            end
        end
        if (rd_fire) begin
            if (rd_cnt_q == LAST) begin
                bank_d[rd_sel_q] = EMPTY;
                rd_cnt_d         = '0;
                rd_sel_d         = ~rd_sel_q;
            end else begin
                bank_d[rd_sel_q] = DRAINING;
                rd_cnt_d         = rd_cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bank_q[0] <= EMPTY;
            bank_q[1] <= EMPTY;
            wr_sel_q  <= 1'b0;
            rd_sel_q  <= 1'b0;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
        end else begin
            bank_q[0] <= bank_d[0];
            bank_q[1] <= bank_d[1];
            wr_sel_q  <= wr_sel_d;
            rd_sel_q  <= rd_sel_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
        end
    end

    // Sample storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            for (int unsigned l = 0; l < LANES; l++) begin
                mem_i[wr_sel_q][L'(L'(wr_cnt_q) * L'(LANES) + L'(l))] <= din_i[l];
                mem_q[wr_sel_q][L'(L'(wr_cnt_q) * L'(LANES) + L'(l))] <= din_q[l];
            end
        end
    end

    always_comb begin
        for (int unsigned l = 0; l < LANES; l++) begin
            raddr[l]  = bitrev(L'(L'(rd_cnt_q) * L'(LANES) + L'(l)));
            dout_i[l] = mem_i[rd_sel_q][raddr[l]];
            dout_q[l] = mem_q[rd_sel_q][raddr[l]];
        end
    end

`ifdef FFT_REORDER_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;
    logic        drop_err_q;
    logic [5:0]  stall_cnt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            frame_cnt_q <= '0;
            drop_err_q  <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            if (rd_fire && (rd_cnt_q == LAST)) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
            // Counter saturates at 63; the 64th consecutive refused cycle sets the sticky flag.
            if (din_valid && !din_ready) begin
                if (stall_cnt_q == 6'd63) begin
                    drop_err_q <= 1'b1;
                end else begin
                    stall_cnt_q <= stall_cnt_q + 6'd1;
                end
            end else begin
                stall_cnt_q <= '0;
            end
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign drop_err  = drop_err_q;
`endif

endmodule

// File: tb/tb_fft_reorder_pp.sv
// Scoreboard bench for fft_reorder_pp (N=512, LANES=16, W=13); frame status outputs checked when FFT_REORDER_FRAME_CNT_EN is defined.
module tb_fft_reorder_pp;

    localparam int N     = 512;
    localparam int LANES = 16;
    localparam int W     = 13;
    localparam int B     = N / LANES;
    localparam int VW    = LANES * W;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic din_valid = 1'b0;
    logic din_ready;
    logic dout_valid;
    logic dout_ready = 1'b1;
    logic dout_sof, dout_eof;
    logic [LANES-1:0][W-1:0] din_i = '0;
    logic [LANES-1:0][W-1:0] din_q = '0;
    logic [LANES-1:0][W-1:0] dout_i, dout_q;
`ifdef FFT_REORDER_FRAME_CNT_EN
    logic [15:0] frame_cnt;
    logic        drop_err;
`endif

    always #5 clk = ~clk;

    fft_reorder_pp #(.N(N), .LANES(LANES), .W(W)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .din_i      (din_i),
        .din_q      (din_q),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_i     (dout_i),
        .dout_q     (dout_q),
        .dout_sof   (dout_sof),
        .dout_eof   (dout_eof)
`ifdef FFT_REORDER_FRAME_CNT_EN
        ,
        .frame_cnt  (frame_cnt),
        .drop_err   (drop_err)
`endif
    );

    typedef struct {
        logic [VW-1:0] i;
        logic [VW-1:0] q;
        logic [1:0]    se;
    } beat_t;

    beat_t exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;
    int hs_n = 0, hs_mark = 0, cyc = 0, first_cyc = 0, last_cyc = 0;
    int stalls = 0;
    int rdy_mode = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int brev(input int a);
        int r;
        r = 0;
        for (int i = 0; i < 9; i++) begin
            if (a[i]) r = r | (1 << (8 - i));
        end
        return r;
    endfunction

    // Sample value = storage address, with a 4-bit frame tag above it to catch lost/duplicated frames.
    function automatic logic [W-1:0] sval(input int tag, input int a);
        return W'((tag % 16) * 512 + a);
    endfunction

    task automatic push_exp(input int tag);
        beat_t b;
        logic [W-1:0] v;
        for (int m = 0; m < B; m++) begin
            for (int l = 0; l < LANES; l++) begin
                v = sval(tag, brev(m * LANES + l));
                b.i[l*W +: W] = v;
                b.q[l*W +: W] = -v;
            end
            b.se = {(m == 0), (m == B - 1)};
            exp_q.push_back(b);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int tag, input int k0, input int nb, input int pvalid);
        int  k;
        int  budget;
        logic acc;
        k = k0;
        budget = 0;
        while (k < k0 + nb) begin
            if (budget > 4000) begin
                chk("send_timeout", 256'(k), 256'(k0 + nb));
                break;
            end
            din_valid = ($urandom_range(0, 99) < pvalid);
            for (int l = 0; l < LANES; l++) begin
                din_i[l] = sval(tag, k * LANES + l);
                din_q[l] = -sval(tag, k * LANES + l);
            end
            if (din_valid && !din_ready) stalls++;
            acc = din_valid && din_ready;
            tick();
            budget++;
            if (acc) k++;
        end
        din_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int budget;
        budget = 0;
        while ((exp_q.size() != 0 || dout_valid) && budget < 3000) begin
            tick();
            budget++;
        end
        chk("drain_queue_empty", 256'(exp_q.size()), 256'd0);
        chk("drain_valid_low", 256'(dout_valid), 256'd0);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        exp_q.delete();
        #1;
        chk("rst_valid_immediate", 256'(dout_valid), 256'd0);
        repeat (3) tick();
        rstn = 1'b1;
        #1;
        chk("rst_din_ready", 256'(din_ready), 256'd1);
        chk("rst_dout_valid", 256'(dout_valid), 256'd0);
`ifdef FFT_REORDER_FRAME_CNT_EN
        chk("rst_frame_cnt", 256'(frame_cnt), 256'd0);
        chk("rst_drop_err", 256'(drop_err), 256'd0);
`endif
        tick();
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       dout_ready = 1'b1;
                1:       dout_ready = 1'($urandom_range(0, 1));
                default: dout_ready = 1'b0;
            endcase
        end
    end

    always @(negedge clk) begin
        beat_t b;
        cyc++;
        if (rstn && dout_valid && dout_ready) begin
            if (hs_n == hs_mark) first_cyc = cyc;
            last_cyc = cyc;
            hs_n++;
            n_tests++;
            assert (exp_q.size() > 0) else begin
                n_fail++;
                $error("FAIL beat_unexpected: observed beat with sof=%0b expected none", dout_sof);
            end
            if (exp_q.size() > 0) begin
                b = exp_q.pop_front();
                chk("dout_i", 256'(dout_i), 256'(b.i));
                chk("dout_q", 256'(dout_q), 256'(b.q));
                chk("sof_eof", 256'({dout_sof, dout_eof}), 256'(b.se));
            end
        end
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL global_timeout: observed no finish expected finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "timeout");
    end

    initial begin
        logic [LANES-1:0][W-1:0] s_i, s_q;
        logic s_sof;
        int changes;
        int budget;

        repeat (3) tick();
        rstn = 1'b1;
        #1;
        chk("reset_din_ready", 256'(din_ready), 256'd1);
        chk("reset_dout_valid", 256'(dout_valid), 256'd0);
        tick();

        // Single frame, latency and explicit lane values of beat 0
        rdy_mode = 0;
        push_exp(0);
        send(0, 0, 31, 100);
        chk("t1_valid_before_last", 256'(dout_valid), 256'd0);
        send(0, 31, 1, 100);
        chk("t1_latency_valid", 256'(dout_valid), 256'd1);
        chk("t1_sof", 256'(dout_sof), 256'd1);
        chk("t1_lane1", 256'(dout_i[1]), 256'd256);
        chk("t1_lane3", 256'(dout_i[3]), 256'd384);
        chk("t1_lane15", 256'(dout_i[15]), 256'd480);
        chk("t1_lane1_q", 256'(dout_q[1]), 256'h1F00);
        wait_drain();

        // Three back-to-back frames
        stalls = 0;
        hs_mark = hs_n;
        push_exp(1);
        push_exp(2);
        push_exp(3);
        send(1, 0, B, 100);
        send(2, 0, B, 100);
        send(3, 0, B, 100);
        wait_drain();
        chk("t2_no_stall", 256'(stalls), 256'd0);
        chk("t2_beats", 256'(hs_n - hs_mark), 256'd96);
        chk("t2_no_gap", 256'(last_cyc - first_cyc), 256'd95);

        // Output stalled: both banks fill, beat 0 held
        rdy_mode = 2;
        tick();
        tick();
        push_exp(4);
        push_exp(5);
        send(4, 0, B, 100);
        send(5, 0, B, 100);
        chk("t3_din_ready_low", 256'(din_ready), 256'd0);
        chk("t3_dout_valid", 256'(dout_valid), 256'd1);
        s_i = dout_i;
        s_q = dout_q;
        s_sof = dout_sof;
        changes = 0;
        din_valid = 1'b1;
        repeat (40) begin
            tick();
            if (dout_i !== s_i || dout_q !== s_q || dout_sof !== s_sof || din_ready !== 1'b0 || dout_valid !== 1'b1)
                changes++;
        end
        chk("t3_hold40", 256'(changes), 256'd0);
`ifdef FFT_REORDER_FRAME_CNT_EN
        chk("t3_drop_err_40", 256'(drop_err), 256'd0);
`endif
        repeat (30) begin
            tick();
            if (dout_i !== s_i || dout_q !== s_q || dout_sof !== s_sof || din_ready !== 1'b0 || dout_valid !== 1'b1)
                changes++;
        end
        chk("t3_hold70", 256'(changes), 256'd0);
`ifdef FFT_REORDER_FRAME_CNT_EN
        chk("t3_drop_err_set", 256'(drop_err), 256'd1);
`endif
        din_valid = 1'b0;
        rdy_mode = 0;
        push_exp(6);
        send(6, 0, B, 100);
        wait_drain();
`ifdef FFT_REORDER_FRAME_CNT_EN
        chk("t3_drop_err_sticky", 256'(drop_err), 256'd1);
`endif

        // Random handshakes, 20 frames
        do_reset();
        hs_mark = hs_n;
        rdy_mode = 1;
        for (int f = 0; f < 20; f++) begin
            push_exp(f + 7);
            send(f + 7, 0, B, 70);
        end
        rdy_mode = 0;
        wait_drain();
        chk("t4_beats", 256'(hs_n - hs_mark), 256'd640);
`ifdef FFT_REORDER_FRAME_CNT_EN
        chk("t4_frame_cnt", 256'(frame_cnt), 256'd20);
`endif

        // Reset mid-fill, then a clean frame
        send(3, 0, 10, 100);
        do_reset();
        push_exp(9);
        send(9, 0, B, 100);
        wait_drain();

        // Reset mid-drain after 5 beats, then a clean frame
        push_exp(10);
        hs_mark = hs_n;
        send(10, 0, B, 100);
        budget = 0;
        while ((hs_n - hs_mark) < 5 && budget < 100) begin
            tick();
            budget++;
        end
        chk("t5_drain_progress", 256'(hs_n - hs_mark), 256'd5);
        chk("t5_valid_before_rst", 256'(dout_valid), 256'd1);
        do_reset();
        push_exp(11);
        send(11, 0, B, 100);
        wait_drain();

        chk("final_queue_empty", 256'(exp_q.size()), 256'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
